// File: rtl/delay_config_sequencer_pkg.sv
// rtl/delay_config_sequencer_pkg.sv - shared encodings and tap constants for the delay sequencer
package delay_config_sequencer_pkg;

    localparam int TAP_WIDTH = 9;
    localparam logic [TAP_WIDTH-1:0] TAP_MAX = 9'd511;

    typedef enum logic [1:0] {
        delay_op_read = 2'd0,
        delay_op_load = 2'd1,
        delay_op_inc  = 2'd2,
        delay_op_dec  = 2'd3
    } delay_op_t;

    localparam logic [1:0] delay_cfg_none = 2'd0;
    localparam logic [1:0] delay_cfg_load = 2'd1;

    typedef enum logic [1:0] {
        seq_idle   = 2'd0,
        seq_load   = 2'd1,
        seq_settle = 2'd2,
        seq_ack    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/delay_config_sequencer_if.sv
// rtl/delay_config_sequencer_if.sv - request/response and delay_config bundle for the sequencer
interface delay_config_sequencer_if;

    logic       delay_request__valid;
    logic [1:0] delay_request__op;
    logic       delay_request__select;
    logic [8:0] delay_request__value;
    logic       delay_response__ack;
    logic [8:0] delay_response__value;
    logic       busy;
    logic [1:0] delay_config__op;
    logic       delay_config__select;
    logic [8:0] delay_config__value;

    // Requester side (calibration engine or host)
    modport master (
        output delay_request__valid, delay_request__op, delay_request__select, delay_request__value,
        input  delay_response__ack, delay_response__value, busy,
        input  delay_config__op, delay_config__select, delay_config__value
    );

    // Sequencer side
    modport slave (
        input  delay_request__valid, delay_request__op, delay_request__select, delay_request__value,
        output delay_response__ack, delay_response__value, busy,
        output delay_config__op, delay_config__select, delay_config__value
    );

endinterface

// File: rtl/delay_tap_saturate.sv
// rtl/delay_tap_saturate.sv - combinational tap add/subtract clamped to 0..511
module delay_tap_saturate
    import delay_config_sequencer_pkg::*;
(
    input  logic [TAP_WIDTH-1:0] tap,
    input  logic [TAP_WIDTH-1:0] step,
    input  logic                 subtract,
    output logic [TAP_WIDTH-1:0] result
);

    logic [TAP_WIDTH:0] sum;
    logic [TAP_WIDTH:0] diff;

    // One extra bit catches carry-out on add and borrow on subtract
    always_comb begin
        sum  = {1'b0, tap} + {1'b0, step};
        diff = {1'b0, tap} - {1'b0, step};
        if (subtract) begin
            result = diff[TAP_WIDTH] ? '0 : diff[TAP_WIDTH-1:0];
        end else begin
            result = sum[TAP_WIDTH] ? TAP_MAX : sum[TAP_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/delay_config_sequencer.sv
// rtl/delay_config_sequencer.sv - sequences tap loads into a cascaded delay pair with shadow taps
module delay_config_sequencer
    import delay_config_sequencer_pkg::*;
#(
    parameter int LOAD_CYCLES   = 2,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clk__enable,
    delay_config_sequencer_if.slave    bus
);

    localparam logic [7:0] LOAD_LAST   = 8'(LOAD_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

    seq_state_t           state;
    seq_state_t           state_next;
    logic [7:0]           count;
    logic                 req_select;
    logic [TAP_WIDTH-1:0] shadow [2];
    logic                 cfg_select;
    logic [TAP_WIDTH-1:0] cfg_value;
    logic [TAP_WIDTH-1:0] sat_result;
    logic [TAP_WIDTH-1:0] new_tap;
    logic                 accept;
    logic                 is_read;

    assign accept  = (state == seq_idle) && bus.delay_request__valid;
    assign is_read = (bus.delay_request__op == delay_op_read);

    delay_tap_saturate u_saturate (
        .tap      (shadow[bus.delay_request__select]),
        .step     (bus.delay_request__value),
        .subtract (bus.delay_request__op == delay_op_dec),
        .result   (sat_result)
    );

    // New tap for the selected line: load takes the value verbatim, inc/dec go through the clamp
    always_comb begin
        new_tap = shadow[bus.delay_request__select];
        case (bus.delay_request__op)
            delay_op_load: new_tap = bus.delay_request__value;
            delay_op_inc:  new_tap = sat_result;
            delay_op_dec:  new_tap = sat_result;
            default:       new_tap = shadow[bus.delay_request__select];
        endcase
    end

    // State register; a low clock enable freezes the sequence in place
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= seq_idle;
        end else if (clk__enable) begin
            state <= state_next;
        end
    end

    // Next-state logic: reads skip straight to ack, writes run the load pulse and settle window
    always_comb begin
        state_next = state;
        case (state)
            seq_idle: begin
                if (bus.delay_request__valid) begin
                    state_next = is_read ? seq_ack : seq_load;
                end
            end
            seq_load: begin
                if (count == LOAD_LAST) begin
                    state_next = (SETTLE_CYCLES == 0) ? seq_ack : seq_settle;
                end
            end
            seq_settle: begin
                if (count == SETTLE_LAST) begin
                    state_next = seq_ack;
                end
            end
            default: state_next = seq_idle;
        endcase
    end

    // Phase counter restarts on every state change so each phase counts from zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clk__enable) begin
            if (state_next != state) begin
                count <= '0;
            end else begin
                count <= count + 8'd1;
            end
        end
    end

    // Capture request fields and commit the shadow tap on the acceptance edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_select <= 1'b0;
            shadow[0]  <= '0;
            shadow[1]  <= '0;
            cfg_select <= 1'b0;
            cfg_value  <= '0;
        end else if (clk__enable && accept) begin
            req_select <= bus.delay_request__select;
            if (!is_read) begin
                shadow[bus.delay_request__select] <= new_tap;
                cfg_select <= bus.delay_request__select;
                cfg_value  <= new_tap;
            end
        end
    end

    // Outputs decoded from state so reset clears the load pulse without waiting for a clock
    always_comb begin
        bus.delay_config__op       = (state == seq_load) ? delay_cfg_load : delay_cfg_none;
        bus.delay_config__select   = cfg_select;
        bus.delay_config__value    = cfg_value;
        bus.delay_response__ack    = (state == seq_ack);
        bus.delay_response__value  = (state == seq_ack) ? shadow[req_select] : '0;
        bus.busy                   = (state != seq_idle);
    end

endmodule
